ps2_controls: RTL and testbench

PS2_CONTROLS -- requirements
Module: ps2_controls

---
 rtl/ps2_controls_pkg.sv | 42 ++++
 rtl/ps2_controls_socd.sv | 60 ++++++
 rtl/ps2_controls.sv | 127 ++++++++++++
 tb/tb_ps2_controls.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_controls_pkg.sv
// Shared constants for ps2_controls: scan-code table, service keys, SOCD modes
// and the index of each control within a player's control vector.
package ps2_controls_pkg;

  localparam int MAX_PLAYERS = 4;
  localparam int NUM_CTRL    = 12;

  localparam int CTRL_RIGHT = 0;
  localparam int CTRL_LEFT  = 1;
  localparam int CTRL_DOWN  = 2;
  localparam int CTRL_UP    = 3;
  localparam int CTRL_B1    = 4;
  localparam int CTRL_B2    = 5;
  localparam int CTRL_B3    = 6;
  localparam int CTRL_START = 7;
  localparam int CTRL_COIN  = 8;
  localparam int CTRL_PAUSE = 9;
  localparam int CTRL_B7    = 10;
  localparam int CTRL_B8    = 11;

  localparam int SOCD_PASS    = 0;
  localparam int SOCD_NEUTRAL = 1;
  localparam int SOCD_LAST    = 2;

  typedef logic [8:0] scan_t;  // {E0-extended, scan code}

  localparam scan_t SVC1_CODE = 9'h005;  // F1
  localparam scan_t SVC2_CODE = 9'h006;  // F2

  // Rows listed highest index first: player 3..0, and per player b8..b1, up, down, left, right.
  localparam logic [3:0][11:0][8:0] KEY_TABLE = '{
    '{9'h034, 9'h033, 9'h044, 9'h03E, 9'h025, 9'h049, 9'h041, 9'h03A, 9'h043, 9'h042, 9'h03B, 9'h04B},
    '{9'h06C, 9'h07A, 9'h04C, 9'h03D, 9'h026, 9'h069, 9'h071, 9'h070, 9'h075, 9'h072, 9'h06B, 9'h074},
    '{9'h035, 9'h02C, 9'h02B, 9'h036, 9'h01E, 9'h02D, 9'h024, 9'h015, 9'h01D, 9'h01B, 9'h01C, 9'h023},
    '{9'h01A, 9'h012, 9'h04D, 9'h02E, 9'h016, 9'h029, 9'h011, 9'h014, 9'h175, 9'h172, 9'h16B, 9'h174}
  };

  function automatic scan_t key_code(input int player, input int ctrl);
    return KEY_TABLE[player[1:0]][ctrl[3:0]];
  endfunction

endpackage

// File: rtl/ps2_controls_socd.sv
// Resolves one axis (positive = right/down, negative = left/up) when both
// opposite directions are active at once.
module ps2_controls_socd
  import ps2_controls_pkg::*;
#(
  parameter int SOCD_MODE = SOCD_PASS
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic pos_raw,
  input  logic neg_raw,
  output logic pos_res,
  output logic neg_res
);

  logic pos_prev;
  logic neg_prev;
  logic last_neg_q;
  logic last_neg_d;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      pos_prev   <= 1'b0;
      neg_prev   <= 1'b0;
      last_neg_q <= 1'b0;
    end else begin
      pos_prev   <= pos_raw;
      neg_prev   <= neg_raw;
      last_neg_q <= last_neg_d;
    end
  end

  // The direction rising this cycle already counts, so the newest press wins without a
  // one-cycle glitch; a simultaneous rise favours the positive direction.
  always_comb begin
    last_neg_d = last_neg_q;
    if (pos_raw && !pos_prev) begin
      last_neg_d = 1'b0;
    end else if (neg_raw && !neg_prev) begin
      last_neg_d = 1'b1;
    end

    pos_res = pos_raw;
    neg_res = neg_raw;
    if (pos_raw && neg_raw) begin
      case (SOCD_MODE)
        SOCD_NEUTRAL: begin
          pos_res = 1'b0;
          neg_res = 1'b0;
        end
        SOCD_LAST: begin
          pos_res = !last_neg_d;
          neg_res = last_neg_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_controls.sv
// Merges PS/2 keyboard keys and joystick bits into per-player control vectors
// with SOCD resolution and per-button autofire.
module ps2_controls
  import ps2_controls_pkg::*;
#(
  parameter int PLAYERS   = 2,
  parameter int BUTTONS   = 6,
  parameter int SOCD_MODE = SOCD_PASS,
  parameter int AF_FRAMES = 2
) (
  input  logic                            clk_sys,
  input  logic                            reset_n,
  input  logic [10:0]                     ps2_key,
  input  logic [PLAYERS*16-1:0]           joystick,
  input  logic [PLAYERS*BUTTONS-1:0]      autofire_en,
  input  logic                            vblank,
  output logic [PLAYERS*(4+BUTTONS)-1:0]  controls,
  output logic [1:0]                      service
);

  localparam int         NCTRL   = 4 + BUTTONS;
  localparam logic [3:0] AF_LAST = 4'(AF_FRAMES - 1);

  logic                     tog_p0;
  logic                     evt_p0;
  logic [9:0]               code_p0;
  logic [1:0]               svc_p1;
  logic [PLAYERS*NCTRL-1:0] key_p1;
  logic [PLAYERS*NCTRL-1:0] ctrl_d;
  logic                     vb_q;
  logic [3:0]               af_cnt;
  logic                     af_phase;

  // p0: toggle edge capture; history follows the input in reset so release is silent
  always_ff @(posedge clk_sys) begin
    tog_p0 <= ps2_key[10];
    if (!reset_n) begin
      evt_p0  <= 1'b0;
      code_p0 <= '0;
    end else begin
      evt_p0  <= ps2_key[10] ^ tog_p0;
      code_p0 <= ps2_key[9:0];
    end
  end

  // p1: key registers
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      svc_p1 <= 2'b00;
    end else if (evt_p0) begin
      if (code_p0[8:0] == SVC1_CODE) svc_p1[0] <= code_p0[9];
      if (code_p0[8:0] == SVC2_CODE) svc_p1[1] <= code_p0[9];
    end
  end

  always_ff @(posedge clk_sys) begin
    vb_q <= vblank;
    if (!reset_n) begin
      af_cnt   <= 4'd0;
      af_phase <= 1'b1;
    end else if (vblank && !vb_q) begin
      if (af_cnt == AF_LAST) begin
        af_cnt   <= 4'd0;
        af_phase <= !af_phase;
      end else begin
        af_cnt <= af_cnt + 4'd1;
      end
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [NCTRL-1:0] raw;
    logic [NCTRL-1:0] res;
    logic             unused_joy;

    for (genvar c = 0; c < NCTRL; c++) begin : g_key
      logic key_q;
      always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
          key_q <= 1'b0;
        end else if (evt_p0 && (code_p0[8:0] == key_code(p, c))) begin
          key_q <= code_p0[9];
        end
      end
      assign key_p1[p*NCTRL+c] = key_q;
    end

    assign raw        = key_p1[p*NCTRL +: NCTRL] | joystick[p*16 +: NCTRL];
    assign unused_joy = ^joystick[p*16+NCTRL +: 16-NCTRL];

    ps2_controls_socd #(.SOCD_MODE(SOCD_MODE)) u_socd_h (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .pos_raw (raw[CTRL_RIGHT]),
      .neg_raw (raw[CTRL_LEFT]),
      .pos_res (res[CTRL_RIGHT]),
      .neg_res (res[CTRL_LEFT])
    );

    ps2_controls_socd #(.SOCD_MODE(SOCD_MODE)) u_socd_v (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .pos_raw (raw[CTRL_DOWN]),
      .neg_raw (raw[CTRL_UP]),
      .pos_res (res[CTRL_DOWN]),
      .neg_res (res[CTRL_UP])
    );

    for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
      assign res[CTRL_B1+b] = raw[CTRL_B1+b] & (af_phase | !autofire_en[p*BUTTONS+b]);
    end

    assign ctrl_d[p*NCTRL +: NCTRL] = res;
  end

  // p2: output registers
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      controls <= '0;
      service  <= 2'b00;
    end else begin
      controls <= ctrl_d;
      service  <= svc_p1;
    end
  end

endmodule

// File: tb/tb_ps2_controls.sv
// Directed bench for ps2_controls: four instances cover default, neutral SOCD,
// last-pressed SOCD and the 4-player/8-button configuration.
module tb_ps2_controls;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        vblank;
  logic        tog;

  logic [31:0] joy_a, joy_n, joy_l;
  logic [11:0] af_a, af_n, af_l;
  logic [19:0] ctl_a, ctl_n, ctl_l;
  logic [1:0]  svc_a, svc_n, svc_l, svc_4;
  logic [63:0] joy_4;
  logic [31:0] af_4;
  logic [47:0] ctl_4;
  logic [7:0]  af_pat;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  ps2_controls dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joy_a),
    .autofire_en(af_a), .vblank(vblank), .controls(ctl_a), .service(svc_a)
  );

  ps2_controls #(.SOCD_MODE(1)) dut_n (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joy_n),
    .autofire_en(af_n), .vblank(vblank), .controls(ctl_n), .service(svc_n)
  );

  ps2_controls #(.SOCD_MODE(2)) dut_l (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joy_l),
    .autofire_en(af_l), .vblank(vblank), .controls(ctl_l), .service(svc_l)
  );

  ps2_controls #(.PLAYERS(4), .BUTTONS(8)) dut_4 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joy_4),
    .autofire_en(af_4), .vblank(vblank), .controls(ctl_4), .service(svc_4)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, ext, code};
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    tog     = 1'b0;
    ps2_key = '0;
    vblank  = 1'b0;
    joy_a = '0; joy_n = '0; joy_l = '0; joy_4 = '0;
    af_a  = '0; af_n  = '0; af_l  = '0; af_4  = '0;
    af_pat = 8'b0011_0011;
    step(2);
    chk("reset_ctl_a", ctl_a, 0);
    chk("reset_svc_a", svc_a, 0);
    chk("reset_ctl_4", ctl_4, 0);
    chk("reset_ctl_l", ctl_l, 0);
    reset_n = 1'b1;
    step(1);

    // ctrl press / release, three-cycle latency
    send_key(1'b1, 1'b0, 8'h14);
    step(2);
    chk("b1_press_early", ctl_a[4], 0);
    step(1);
    chk("b1_press", ctl_a, 20'h00010);
    send_key(1'b0, 1'b0, 8'h14);
    step(2);
    chk("b1_release_early", ctl_a[4], 1);
    step(1);
    chk("b1_release", ctl_a[4], 0);

    // extended vs plain 0x75
    send_key(1'b1, 1'b0, 8'h75);
    step(3);
    chk("plain75_not_up", ctl_a[3], 0);
    chk("plain75_p2_up", ctl_4[2*12+3], 1);
    send_key(1'b1, 1'b1, 8'h75);
    step(3);
    chk("e075_up", ctl_a[3], 1);

    // back-to-back events
    send_key(1'b0, 1'b1, 8'h75);
    step(1);
    send_key(1'b0, 1'b0, 8'h75);
    step(3);
    chk("b2b_release_up", ctl_a[3], 0);
    chk("b2b_release_p2", ctl_4[2*12+3], 0);
    send_key(1'b1, 1'b0, 8'h16);
    step(1);
    send_key(1'b1, 1'b0, 8'h05);
    step(3);
    chk("start_held", ctl_a[7], 1);
    chk("service1", svc_a, 2'b01);

    // reset while held; toggle during reset must not become an event
    reset_n = 1'b0;
    send_key(1'b1, 1'b0, 8'h29);
    step(1);
    reset_n = 1'b1;
    chk("reset_clears_ctl", ctl_a, 0);
    chk("reset_clears_svc", svc_a, 0);
    step(4);
    chk("start_stays_0", ctl_a, 0);
    chk("svc_stays_0", svc_a, 0);

    // autofire on b1, plain b2 alongside
    af_a[0]    = 1'b1;
    joy_a[5:4] = 2'b11;
    step(1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("af_b1_frame%0d", i), ctl_a[4], af_pat[i]);
      chk($sformatf("af_b2_frame%0d", i), ctl_a[5], 1);
      vblank = 1'b1;
      step(1);
      vblank = 1'b0;
      step(2);
    end
    for (int i = 0; i < 2; i++) begin
      vblank = 1'b1;
      step(1);
      vblank = 1'b0;
      step(2);
    end
    chk("af_phase_low", ctl_a[4], 0);
    af_a[0] = 1'b0;
    step(1);
    chk("af_disable", ctl_a[4], 1);
    af_a[0] = 1'b1;
    step(1);
    chk("af_reenable", ctl_a[4], 0);
    joy_a = '0;
    af_a  = '0;
    step(1);
    chk("af_clear", ctl_a, 0);

    // SOCD pass-through and neutral
    joy_a[1:0] = 2'b11;
    joy_n[1:0] = 2'b11;
    joy_n[3:2] = 2'b11;
    step(1);
    chk("socd_pass_lr", ctl_a[3:0], 4'b0011);
    chk("socd_neutral_both", ctl_n[3:0], 4'b0000);
    joy_n[0] = 1'b0;
    joy_n[2] = 1'b0;
    step(1);
    chk("socd_neutral_left", ctl_n[3:0], 4'b1010);
    joy_a = '0;
    joy_n = '0;

    // SOCD last-pressed-wins
    joy_l[1] = 1'b1;
    step(1);
    chk("socd_last_left", ctl_l[1:0], 2'b10);
    joy_l[0] = 1'b1;
    step(1);
    chk("socd_last_right", ctl_l[1:0], 2'b01);
    joy_l[0] = 1'b0;
    step(1);
    chk("socd_last_back_left", ctl_l[1:0], 2'b10);
    joy_l = '0;
    step(1);
    joy_l[3:2] = 2'b11;
    step(1);
    chk("socd_same_cycle_down", ctl_l[3:0], 4'b0100);
    joy_l = '0;

    // 4 players x 8 buttons: player 3 b8 only
    joy_4[3*16+11] = 1'b1;
    step(1);
    chk("p3_b8_only", ctl_4, 64'h0000_8000_0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
